// File: rtl/pipelined_carry_select_subtractor_pkg.sv
// Shared arithmetic helpers for the carry-select subtractor slice:
// block count, clog2 and the width-divisibility check used at elaboration.
package pipelined_carry_select_subtractor_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int num_blocks(input int width, input int block_width);
      return width / block_width;
   endfunction

   function automatic bit widths_ok(input int width, input int block_width, input int sub_block_width);
      return (block_width > 0) && (sub_block_width > 0) &&
             (width % block_width == 0) && (block_width % sub_block_width == 0);
   endfunction

endpackage

// File: rtl/pipelined_carry_select_subtractor_block.sv
// One carry-select slice: two lookahead adders evaluate A + ~B for both
// possible borrow-ins so the select chain only has to pick a result.
module blocked_carry_lookahead_adder #(
   parameter int WIDTH       = 8,
   parameter int GROUP_WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int NUM_GROUPS = WIDTH / GROUP_WIDTH;

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Group generate/propagate skip the ripple between groups; bits inside a group ripple.
   always_comb begin : lookahead
      logic [NUM_GROUPS:0] group_carry;
      logic [WIDTH-1:0]    carry;
      logic                grp_gen;
      logic                grp_prop;
      group_carry    = '0;
      carry          = '0;
      grp_gen        = 1'b0;
      grp_prop       = 1'b1;
      group_carry[0] = carry_in;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         grp_gen  = 1'b0;
         grp_prop = 1'b1;
         for (int i = 0; i < GROUP_WIDTH; i++) begin
            grp_gen  = gen[g*GROUP_WIDTH+i] | (prop[g*GROUP_WIDTH+i] & grp_gen);
            grp_prop = grp_prop & prop[g*GROUP_WIDTH+i];
         end
         group_carry[g+1] = grp_gen | (grp_prop & group_carry[g]);
      end
      for (int g = 0; g < NUM_GROUPS; g++) begin
         carry[g*GROUP_WIDTH] = group_carry[g];
         for (int i = 0; i < GROUP_WIDTH - 1; i++) begin
            carry[g*GROUP_WIDTH+i+1] = gen[g*GROUP_WIDTH+i] |
                                       (prop[g*GROUP_WIDTH+i] & carry[g*GROUP_WIDTH+i]);
         end
      end
      sum       = prop ^ carry;
      carry_out = group_carry[NUM_GROUPS];
   end
endmodule

module block_select_subtractor #(
   parameter int BLOCK_WIDTH     = 8,
   parameter int SUB_BLOCK_WIDTH = 4
) (
   input  logic [BLOCK_WIDTH-1:0] a,
   input  logic [BLOCK_WIDTH-1:0] b,
   output logic [BLOCK_WIDTH-1:0] d0,
   output logic [BLOCK_WIDTH-1:0] d1,
   output logic                   bout0,
   output logic                   bout1
);
   logic [BLOCK_WIDTH-1:0] b_inv;
   logic                   carry0;
   logic                   carry1;

   assign b_inv = ~b;

   // Borrow-in 0 maps to carry-in 1 in the two's-complement form.
   blocked_carry_lookahead_adder #(.WIDTH(BLOCK_WIDTH), .GROUP_WIDTH(SUB_BLOCK_WIDTH)) u_add0 (
      .a(a), .b(b_inv), .carry_in(1'b1), .sum(d0), .carry_out(carry0)
   );

   blocked_carry_lookahead_adder #(.WIDTH(BLOCK_WIDTH), .GROUP_WIDTH(SUB_BLOCK_WIDTH)) u_add1 (
      .a(a), .b(b_inv), .carry_in(1'b0), .sum(d1), .carry_out(carry1)
   );

   assign bout0 = ~carry0;
   assign bout1 = ~carry1;
endmodule

// File: rtl/pipelined_carry_select_subtractor.sv
// Two-stage carry-select subtractor: stage 1 registers both borrow cases per
// block, stage 2 resolves the borrow chain; valid/ready on both sides.
module pipelined_carry_select_subtractor
   import pipelined_carry_select_subtractor_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int BLOCK_WIDTH     = 8,
   parameter int SUB_BLOCK_WIDTH = 4
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iBin,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oD,
   output logic             oBout,
   output logic             oV,
   output logic             oZ
);
   localparam int NB = num_blocks(WIDTH, BLOCK_WIDTH);

   if (!widths_ok(WIDTH, BLOCK_WIDTH, SUB_BLOCK_WIDTH)) begin : g_width_check
      $error("WIDTH must be a multiple of BLOCK_WIDTH, which must be a multiple of SUB_BLOCK_WIDTH");
   end

   logic [WIDTH-1:0] blk_d0;
   logic [WIDTH-1:0] blk_d1;
   logic [NB-1:0]    blk_bout0;
   logic [NB-1:0]    blk_bout1;

   for (genvar k = 0; k < NB; k++) begin : g_block
      block_select_subtractor #(.BLOCK_WIDTH(BLOCK_WIDTH), .SUB_BLOCK_WIDTH(SUB_BLOCK_WIDTH)) u_block (
         .a    (iA[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .b    (iB[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .d0   (blk_d0[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .d1   (blk_d1[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .bout0(blk_bout0[k]),
         .bout1(blk_bout1[k])
      );
   end

   logic             s1_valid;
   logic [WIDTH-1:0] s1_d0;
   logic [WIDTH-1:0] s1_d1;
   logic [NB-1:0]    s1_bout0;
   logic [NB-1:0]    s1_bout1;
   logic             s1_bin;
   logic             s1_amsb;
   logic             s1_bmsb;
   logic             adv1;
   logic             adv2;

   // oReady is combinational on iReady: no skid buffer, a full pipe drains in lockstep.
   assign adv2   = !oValid || iReady;
   assign adv1   = !s1_valid || adv2;
   assign oReady = adv1;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         s1_valid <= 1'b0;
         s1_d0    <= '0;
         s1_d1    <= '0;
         s1_bout0 <= '0;
         s1_bout1 <= '0;
         s1_bin   <= 1'b0;
         s1_amsb  <= 1'b0;
         s1_bmsb  <= 1'b0;
      end else if (adv1) begin
         s1_valid <= iValid;
         s1_d0    <= blk_d0;
         s1_d1    <= blk_d1;
         s1_bout0 <= blk_bout0;
         s1_bout1 <= blk_bout1;
         s1_bin   <= iBin;
         s1_amsb  <= iA[WIDTH-1];
         s1_bmsb  <= iB[WIDTH-1];
      end
   end

   logic [WIDTH-1:0] sel_d;
   logic             sel_bout;
   logic             sel_v;

   always_comb begin : select_chain
      logic borrow;
      borrow = s1_bin;
      sel_d  = '0;
      for (int k = 0; k < NB; k++) begin
         sel_d[k*BLOCK_WIDTH +: BLOCK_WIDTH] = borrow ? s1_d1[k*BLOCK_WIDTH +: BLOCK_WIDTH]
                                                      : s1_d0[k*BLOCK_WIDTH +: BLOCK_WIDTH];
         borrow = borrow ? s1_bout1[k] : s1_bout0[k];
      end
      sel_bout = borrow;
      sel_v    = (s1_amsb != s1_bmsb) && (sel_d[WIDTH-1] != s1_amsb);
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oValid <= 1'b0;
         oD     <= '0;
         oBout  <= 1'b0;
         oV     <= 1'b0;
         oZ     <= 1'b0;
      end else if (adv2) begin
         oValid <= s1_valid;
         oD     <= sel_d;
         oBout  <= sel_bout;
         oV     <= sel_v;
         oZ     <= ~|sel_d;
      end
   end
endmodule

// File: doc/pipelined_carry_select_subtractor.md
Name: pipelined_carry_select_subtractor

Overview:
- Two-stage pipelined carry-select subtractor computing oD = iA - iB - iBin, with borrow-out, signed-overflow and zero flags.
- Built from blocked lookahead adders (A + ~B + ~Bin). Blocks pre-compute both borrow-in cases in stage 1; stage 2 resolves the borrow-select chain.
- Valid/ready handshake on both sides so it drops into datapaths with backpressure.
- Companion to the fast adders in the arithmetic library.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 8, carry-select block width; must be a multiple of SUB_BLOCK_WIDTH.
- SUB_BLOCK_WIDTH, 4, lookahead group width inside each block adder.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iValid  input  1  upstream operands valid.
- oReady  output  1  block can accept operands this cycle.
- iA  input  WIDTH  minuend.
- iB  input  WIDTH  subtrahend.
- iBin  input  1  borrow-in (1 = subtract an extra 1).
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts result.
- oD  output  WIDTH  difference, modulo 2^WIDTH.
- oBout  output  1  borrow-out: 1 iff unsigned iA < iB + iBin.
- oV  output  1  signed overflow.
- oZ  output  1  oD == 0.

Behaviour:
- Reset, async on iRstN low: both stage valid bits = 0, oValid = 0, oD = 0, oBout = 0, oV = 0, oZ = 0. Release is synchronous to iClk.
- Arithmetic per block k, k = 0 .. WIDTH/BLOCK_WIDTH-1:
  - Compute D0 = A_k + ~B_k + 1 (borrow-in 0) and D1 = A_k + ~B_k + 0 (borrow-in 1).
  - Borrow-out of each case = inverted carry-out.
- Stage 1 register captures: D0/D1 and borrow-outs for all blocks, iBin, iA[WIDTH-1], iB[WIDTH-1], and valid.
- Stage 2, combinational select chain then output register:
  - b[0] = registered iBin; b[k+1] = b[k] ? Bout1_k : Bout0_k.
  - D_k = b[k] ? D1_k : D0_k; oBout = final b.
  - oV = (A_msb != B_msb) && (D_msb != A_msb).
  - oZ = ~|D.
- Latency: operands accepted on cycle N (iValid && oReady) appear with oValid = 1 in cycle N+2 when no stall. Throughput is 1 per cycle.
- Handshake:
  - adv2 = !oValid || iReady.
  - adv1 = !s1_valid || adv2.
  - oReady = adv1.
  - Stage 1 loads when adv1; s1_valid <= iValid.
  - Stage 2 loads when adv2; oValid <= s1_valid.
- Stall: while oValid && !iReady, oD/oBout/oV/oZ/oValid hold stable. Stage 1 holds if full; oReady drops only when both stages are full.
- oReady depends combinationally on iReady, so there is no internal skid buffer. Upstream must not make iValid depend on oReady.
- Simultaneous: output consumed and new input accepted in the same cycle gives no bubble.
- Bubbles: payload registers may load with iValid = 0; the data is don't-care, but valid bits must be exact.
- Mid-operation reset drops all in-flight results; no result is emitted after reset.
- Upstream must hold iA/iB/iBin stable while iValid && !oReady.

Decomposition:
- Shared arith package:
  - NUM_BLOCKS = WIDTH/BLOCK_WIDTH.
  - Function clog2.
  - Elaboration-time checks for the divisibility constraints.
- Sub-module block_select_subtractor (one BLOCK_WIDTH slice): instantiates two blocked_carry_lookahead_adder instances with ~B and carry-in 1/0, and outputs D0, D1, Bout0, Bout1. Top-level generate loop instantiates NUM_BLOCKS of these plus the pipeline registers and select chain.

Test Plan:
- Reset: hold iRstN=0 with iValid=1 -> oValid=0, oD=0, oBout=0, oV=0, oZ=0; after release, first result appears exactly 2 cycles after acceptance.
- Borrow ripple through all blocks: iA=0x00000000, iB=0x00000001, iBin=0 -> oD=0xFFFFFFFF, oBout=1, oV=0, oZ=0. Then iA=0x00000100, iB=0, iBin=1 -> oD=0x000000FF, oBout=0.
- Signed overflow: iA=0x80000000, iB=0x00000001 -> oD=0x7FFFFFFF, oV=1, oBout=0. Then iA=0x7FFFFFFF, iB=0xFFFFFFFF -> oD=0x80000000, oV=1, oBout=1.
- Zero/equal: iA=iB=0x12345678, iBin=0 -> oD=0, oZ=1, oBout=0. Same operands with iBin=1 -> oD=0xFFFFFFFF, oBout=1, oZ=0.
- Backpressure: stream 4 back-to-back ops with iReady=0 for 3 cycles mid-stream -> oReady low once both stages are full; outputs hold stable; all 4 results delivered in order with none lost or duplicated.
- Random: 10k random iA/iB/iBin with random iValid/iReady -> scoreboard matches {oBout,oD} = {1'b0,iA} - iB - iBin, plus the oV/oZ reference model. Repeat with WIDTH=16, BLOCK_WIDTH=4, SUB_BLOCK_WIDTH=2.
